// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bus between the 5-stage datapath and hazard_ctrl.
// The master side is the datapath, and the slave side is the sequencer.
interface hazard_ctrl_if;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemTimeout;
    logic [31:0] StallCycles, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage core, including start-up flushing and memory wait states.
// The optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_ctrl #(
    parameter int unsigned INIT_FLUSH  = 2,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned ICW = 4;
    localparam int unsigned WCW = 8;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT} state_t;

    state_t         state, state_nxt;
    logic [ICW-1:0] init_cnt, init_cnt_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic           mem_timeout, mem_timeout_nxt;
    logic           load_use, mem_stall;
    logic           stall_f, stall_d, stall_e, stall_m;
    logic           flush_d, flush_e, flush_w;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_INIT;
            init_cnt    <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_cnt_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= mem_timeout_nxt;
        end
    end

    // Next state and pipeline controls; memory wait beats branch beats load-use
    always_comb begin
        state_nxt       = state;
        init_cnt_nxt    = init_cnt;
        wait_cnt_nxt    = wait_cnt;
        mem_timeout_nxt = mem_timeout;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;

        load_use  = bus.ResultSrcE && (bus.RdE != 5'd0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
        mem_stall = bus.MemReqM && !bus.MemReadyM;

        case (state)
            S_INIT: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (init_cnt == ICW'(INIT_FLUSH - 1)) begin
                    init_cnt_nxt = '0;
                    state_nxt    = S_RUN;
                end else begin
                    init_cnt_nxt = init_cnt + ICW'(1);
                end
            end
            S_RUN: begin
                if (mem_stall) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w      = 1'b1;
                    wait_cnt_nxt = WCW'(1);
                    state_nxt    = S_MEM_WAIT;
                end else if (bus.PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                flush_w = 1'b1;
                // A dropped request counts as completion
                if (bus.MemReadyM || !bus.MemReqM) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_RUN;
                end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                    mem_timeout_nxt = 1'b1;
                    wait_cnt_nxt    = '0;
                    state_nxt       = S_RUN;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Forward selects: M result has priority over W, and x0 never forwards
    always_comb begin
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;
        if (RST_N) begin
            if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs1E))
                bus.ForwardAE = 2'b10;
            else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs1E))
                bus.ForwardAE = 2'b01;
            if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs2E))
                bus.ForwardBE = 2'b10;
            else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs2E))
                bus.ForwardBE = 2'b01;
        end
    end

    assign bus.StallF     = stall_f;
    assign bus.StallD     = stall_d;
    assign bus.StallE     = stall_e;
    assign bus.StallM     = stall_m;
    assign bus.FlushD     = flush_d;
    assign bus.FlushE     = flush_e;
    assign bus.FlushW     = flush_w;
    assign bus.MemTimeout = mem_timeout;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;

    // Start-up flushing is not a pipeline event, so INIT cycles are not counted
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (state != S_INIT) begin
            if (stall_f) stall_cycles <= stall_cycles + 32'd1;
            if (flush_e) flush_count  <= flush_count + 32'd1;
        end
    end

    assign bus.StallCycles = stall_cycles;
    assign bus.FlushCount  = flush_count;
`else
    assign bus.StallCycles = 32'd0;
    assign bus.FlushCount  = 32'd0;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage core.
- Generates stall, flush and forward-select controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers load-use hazards, taken branches, data-memory wait states and start-up pipeline clearing.
- The pipeline registers have no reset, so this block flushes them after reset release.

Parameters:
- INIT_FLUSH, 2: cycles FlushD/FlushE are held high after reset release (range 1-15).
- MEM_TIMEOUT, 16: maximum consecutive wait cycles before a memory access is abandoned (range 2-255).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source/destination registers in Execute
- ResultSrcE  in  1  1 = instruction in Execute is a load
- PCSrcE  in  1  branch/jump taken, resolved in Execute
- RdM  in  5, RegWriteM  in  1  Memory-stage write-back info
- RdW  in  5, RegWriteW  in  1  Writeback-stage write-back info
- MemReqM  in  1  data-memory access in Memory stage
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  load a bubble into IF/ID, ID/EX, MEM/WB
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALU result from M, 01 = result from W
- MemTimeout  out  1  sticky error flag
- StallCycles, FlushCount  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-low (RST_N low). Clears state to INIT, init counter and wait counter to 0, MemTimeout to 0.
- While RST_N is low: FlushD = FlushE = 1; all stalls, FlushW and forward selects = 0.
- Control outputs are combinational from state plus inputs. State, counters and MemTimeout are registered.
- FSM states: INIT, RUN, MEM_WAIT.
- INIT:
  - FlushD = FlushE = 1, all stalls 0, MemReqM ignored.
  - Stays for INIT_FLUSH cycles after RST_N rises, then goes to RUN.
- RUN, evaluated in this priority order:
  1. Memory wait: MemReqM=1 and MemReadyM=0.
     - StallF = StallD = StallE = StallM = 1, FlushW = 1, all other flushes 0.
     - Wait counter loads 1; next state MEM_WAIT.
     - PCSrcE and load-use are ignored this cycle (E is frozen and re-evaluated later).
  2. Branch taken: PCSrcE = 1.
     - FlushD = FlushE = 1, StallF = StallD = 0.
     - A coincident load-use condition is discarded, since the Decode instruction is wrong-path.
  3. Load-use: ResultSrcE = 1, RdE != 0, and (RdE == Rs1D or RdE == Rs2D).
     - StallF = StallD = 1, FlushE = 1, for exactly one cycle.
     - The next cycle re-evaluates with the load in M.
  4. Otherwise: all stall/flush outputs 0.
- MEM_WAIT:
  - Same outputs as the memory-wait case above.
  - MemReadyM = 1: outputs stay as above this cycle (the W bubble stays), wait counter clears, next state RUN.
  - MemReadyM = 0 with wait counter = MEM_TIMEOUT - 1: set MemTimeout (sticky until reset), clear counter, go to RUN; the access is abandoned.
  - Otherwise the wait counter increments. It saturates by construction and never wraps.
  - MemReqM dropping to 0 while in MEM_WAIT is treated as completion.
- Forwarding is combinational in every state.
  - ForwardAE = 10 if RegWriteM and RdM != 0 and RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW and RdW != 0 and RdW == Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE follows the same rule using Rs2E. The M match has priority over W.
- Register x0 is never a hazard or forward source.
- RST_N asserted mid-MEM_WAIT: returns immediately to INIT outputs. No timeout is recorded.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - StallCycles increments every cycle StallF = 1 outside INIT.
  - FlushCount increments once per cycle FlushE = 1 outside INIT.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports are driven constant 0 and no counter registers exist.

Test Plan:
- Reset release with INIT_FLUSH=2 -> FlushD = FlushE = 1 for exactly 2 cycles after RST_N rises, then all stall/flush outputs 0.
- Load x5 in E (ResultSrcE=1, RdE=5), Rs1D=5 -> StallF = StallD = FlushE = 1 for one cycle, then 0 once RdE changes. Repeating with RdE=0 -> no stall.
- PCSrcE=1 together with a load-use match -> FlushD = FlushE = 1, StallF = StallD = 0.
- MemReqM=1, MemReadyM low 3 cycles then high -> StallF/D/E/M and FlushW high for 4 cycles, back in RUN on cycle 5, MemTimeout = 0.
- MemReqM=1, MemReadyM never asserts, MEM_TIMEOUT=16 -> stalls for 16 cycles, then MemTimeout = 1, stalls release, and MemTimeout stays 1 until RST_N goes low.
- Forwarding: RdM = RdW = Rs1E = 7 with both RegWrite bits set -> ForwardAE = 10. With RegWriteM=0 -> 01. With Rs1E=0 -> 00.
